// File: rtl/riscv_package.sv
// rtl/riscv_package.sv - shared RV32I/RV64I decode types, funct7 constants and XLEN-aware immediate helpers
package riscv_package;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    reg_write;
    logic    alu_source;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
  } control_signals_t;

  localparam logic [6:0] FUNCT7_BASE      = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT       = 7'b0100000;
  localparam logic [6:0] OP_MULDIV_FUNCT7 = 7'b0000001;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    control_signals_t control;
    logic             illegal;
    logic             muldiv;
  } decode_result_t;

  // Upper word is only meaningful for RV64; RV32 callers keep the low 32 bits.
  function automatic logic [63:0] sext_word(input logic [31:0] v, input int xlen);
    return (xlen == 64) ? {{32{v[31]}}, v} : {32'h0, v};
  endfunction

  function automatic logic [63:0] imm_i(input logic [31:0] i, input int xlen);
    return sext_word({{20{i[31]}}, i[31:20]}, xlen);
  endfunction

  function automatic logic [63:0] imm_s(input logic [31:0] i, input int xlen);
    return sext_word({{20{i[31]}}, i[31:25], i[11:7]}, xlen);
  endfunction

  function automatic logic [63:0] imm_b(input logic [31:0] i, input int xlen);
    return sext_word({{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}, xlen);
  endfunction

  function automatic logic [63:0] imm_u(input logic [31:0] i, input int xlen);
    return sext_word({i[31:12], 12'h000}, xlen);
  endfunction

  function automatic logic [63:0] imm_j(input logic [31:0] i, input int xlen);
    return sext_word({{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}, xlen);
  endfunction

endpackage

// File: rtl/riscv_decode_logic.sv
// rtl/riscv_decode_logic.sv - combinational instruction decode and illegal check
// RISCV_MEXT_EN makes OP/funct7=0000001 a legal muldiv operation.
module riscv_decode_logic
  import riscv_package::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output decode_result_t  result,
  output logic [XLEN-1:0] immediate
);

  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [63:0]      imm_full;
  logic             ill;
  logic             md;
  logic             shift_ok;
  control_signals_t ctl;
  logic             unused_imm;

  assign f3 = instruction[14:12];
  assign f7 = instruction[31:25];
  assign immediate  = imm_full[XLEN-1:0];
  assign unused_imm = ^imm_full;

  always_comb begin
    ctl        = '0;
    ctl.alu_op = ALU_ADD;
    imm_full   = '0;
    md         = 1'b0;
    ill        = (instruction[1:0] != 2'b11);
    if (XLEN == 32) shift_ok = (f7 == FUNCT7_BASE) || (f7 == FUNCT7_ALT);
    else            shift_ok = (instruction[31:26] == 6'b000000) || (instruction[31:26] == 6'b010000);

    case (instruction[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm_full = imm_u(instruction, XLEN);
        ctl.reg_write = 1'b1;  ctl.alu_source = 1'b1;
      end
      OPC_JAL: begin
        imm_full = imm_j(instruction, XLEN);
        ctl.reg_write = 1'b1;  ctl.alu_source = 1'b1;  ctl.jump = 1'b1;
      end
      OPC_JALR: begin
        imm_full = imm_i(instruction, XLEN);
        ctl.reg_write = 1'b1;  ctl.alu_source = 1'b1;  ctl.jump = 1'b1;
        if (f3 != 3'b000) ill = 1'b1;
      end
      OPC_BRANCH: begin
        imm_full = imm_b(instruction, XLEN);
        ctl.alu_op = ALU_SUB;  ctl.branch = 1'b1;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      OPC_LOAD: begin
        imm_full = imm_i(instruction, XLEN);
        ctl.reg_write = 1'b1;  ctl.alu_source = 1'b1;  ctl.mem_read = 1'b1;
        if (f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110))) ill = 1'b1;
      end
      OPC_STORE: begin
        imm_full = imm_s(instruction, XLEN);
        ctl.alu_source = 1'b1;  ctl.mem_write = 1'b1;
        if (f3[2] || (XLEN == 32 && f3 == 3'b011)) ill = 1'b1;
      end
      OPC_OPIMM: begin
        imm_full = imm_i(instruction, XLEN);
        ctl.reg_write  = 1'b1;  ctl.alu_source = 1'b1;
        ctl.alu_op     = alu_op_t'({(f3 == 3'b101) ? instruction[30] : 1'b0, f3});
        if ((f3 == 3'b001 || f3 == 3'b101) && !shift_ok) ill = 1'b1;
        if (f3 == 3'b001 && instruction[30]) ill = 1'b1;
      end
      OPC_OP: begin
        ctl.reg_write = 1'b1;
        ctl.alu_op    = alu_op_t'({f7[5], f3});
        if (f7 == OP_MULDIV_FUNCT7) begin
`ifdef RISCV_MEXT_EN
          md         = 1'b1;
          ctl.alu_op = ALU_ADD;
`else
          ill = 1'b1;
`endif
        end else if (!(f7 == FUNCT7_BASE || (f7 == FUNCT7_ALT && (f3 == 3'b000 || f3 == 3'b101)))) begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase

    // Illegal entries still travel down the pipe but must not trigger any side effect.
    if (ill) begin
      ctl = '0;
      md  = 1'b0;
    end
  end

  always_comb begin
    result         = '0;
    result.opcode  = instruction[6:0];
    result.rd      = instruction[11:7];
    result.rs1     = instruction[19:15];
    result.rs2     = instruction[24:20];
    result.funct3  = f3;
    result.funct7  = f7;
    result.control = ctl;
    result.illegal = ill;
    result.muldiv  = md;
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - RV32I/RV64I decode stage with two-entry skid buffer and registered in_ready
// RISCV_MEXT_EN enables M-extension decode in riscv_decode_logic.
module riscv_decode_stage
  import riscv_package::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_immediate,
  output logic [9:0]      out_control,
  output logic            out_illegal,
  output logic            out_muldiv
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("riscv_decode_stage: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} buf_state_t;

  buf_state_t      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  decode_result_t  dec, head_q, head_d, skid_q, skid_d;
  logic [XLEN-1:0] dec_imm, head_imm_q, head_imm_d, skid_imm_q, skid_imm_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
  logic            accept, pop;

  riscv_decode_logic #(.XLEN(XLEN)) u_decode (
    .instruction (in_instruction),
    .result      (dec),
    .immediate   (dec_imm)
  );

  assign accept = in_valid && in_ready_q;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    head_d     = head_q;
    head_imm_d = head_imm_q;
    head_pc_d  = head_pc_q;
    skid_d     = skid_q;
    skid_imm_d = skid_imm_q;
    skid_pc_d  = skid_pc_q;
    if (flush) begin
      state_d    = ST_EMPTY;
      in_ready_d = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          head_d = dec;  head_imm_d = dec_imm;  head_pc_d = in_pc;
          state_d = ST_ONE;
        end
        ST_ONE: begin
          if (accept && !pop) begin
            skid_d = dec;  skid_imm_d = dec_imm;  skid_pc_d = in_pc;
            state_d    = ST_FULL;
            in_ready_d = 1'b0;
          end else if (accept && pop) begin
            head_d = dec;  head_imm_d = dec_imm;  head_pc_d = in_pc;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (pop) begin
          head_d = skid_q;  head_imm_d = skid_imm_q;  head_pc_d = skid_pc_q;
          state_d    = ST_ONE;
          in_ready_d = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      head_imm_q <= '0;
      head_pc_q  <= '0;
      skid_q     <= '0;
      skid_imm_q <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      head_imm_q <= head_imm_d;
      head_pc_q  <= head_pc_d;
      skid_q     <= skid_d;
      skid_imm_q <= skid_imm_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != ST_EMPTY);
  assign out_pc        = out_valid ? head_pc_q : RESET_PC_TAG;
  assign out_opcode    = head_q.opcode;
  assign out_rd        = head_q.rd;
  assign out_rs1       = head_q.rs1;
  assign out_rs2       = head_q.rs2;
  assign out_funct3    = head_q.funct3;
  assign out_funct7    = head_q.funct7;
  assign out_immediate = head_imm_q;
  assign out_control   = head_q.control;
  assign out_illegal   = head_q.illegal;
  assign out_muldiv    = head_q.muldiv;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb/tb_riscv_decode_stage.sv - scoreboard bench driving an RV64 and an RV32 decode stage in lockstep
module tb_riscv_decode_stage;

  localparam logic [63:0] TAG64 = 64'hDEAD_BEEF_0000_0100;
  localparam logic [31:0] TAG32 = 32'h0000_0F00;
  localparam logic [3:0]  A_ADD = 4'b0000, A_SLL = 4'b0001, A_SUB = 4'b1000, A_SRA = 4'b1101;

  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instruction = '0;
  logic [63:0] in_pc = '0;

  logic        r64, v64, il64, md64, r32, v32, il32, md32;
  logic [63:0] pc64, imm64;
  logic [31:0] pc32, imm32;
  logic [6:0]  op64, f7_64, op32, f7_32;
  logic [4:0]  rd64, rs1_64, rs2_64, rd32, rs1_32, rs2_32;
  logic [2:0]  f3_64, f3_32;
  logic [9:0]  c64, c32;

  always #5 clk = ~clk;

  riscv_decode_stage #(.XLEN(64), .RESET_PC_TAG(TAG64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instruction(in_instruction), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
    .out_pc(pc64), .out_opcode(op64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_funct3(f3_64), .out_funct7(f7_64), .out_immediate(imm64), .out_control(c64),
    .out_illegal(il64), .out_muldiv(md64));

  riscv_decode_stage #(.XLEN(32), .RESET_PC_TAG(TAG32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instruction(in_instruction), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_pc(pc32), .out_opcode(op32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_funct3(f3_32), .out_funct7(f7_32), .out_immediate(imm32), .out_control(c32),
    .out_illegal(il32), .out_muldiv(md32));

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [9:0]  c64;
    logic [9:0]  c32;
    logic        ill64;
    logic        ill32;
    logic        md;
  } exp_t;

  exp_t vec[$];
  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [9:0] ctl(input logic [3:0] a, input logic rw, input logic src,
                                     input logic mr, input logic mw, input logic br, input logic j);
    return {a, rw, src, mr, mw, br, j};
  endfunction

  function automatic exp_t mk(input logic [31:0] instr, input logic [63:0] imm, input logic [9:0] k64,
                              input logic [9:0] k32, input logic i64, input logic i32, input logic md);
    exp_t e;
    e.instr = instr;  e.pc = '0;  e.imm = imm;  e.c64 = k64;  e.c32 = k32;
    e.ill64 = i64;    e.ill32 = i32;  e.md = md;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && v64 && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output_pc", pc64, 64'h0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("valid32@%08h", mon_e.instr), 64'(v32), 64'd1);
        chk($sformatf("pc64@%08h", mon_e.instr), pc64, mon_e.pc);
        chk($sformatf("pc32@%08h", mon_e.instr), 64'(pc32), {32'h0, mon_e.pc[31:0]});
        chk($sformatf("opcode@%08h", mon_e.instr), 64'(op64), 64'(mon_e.instr[6:0]));
        chk($sformatf("rd64@%08h", mon_e.instr), 64'(rd64), 64'(mon_e.instr[11:7]));
        chk($sformatf("rd32@%08h", mon_e.instr), 64'(rd32), 64'(mon_e.instr[11:7]));
        chk($sformatf("rs1@%08h", mon_e.instr), 64'(rs1_64), 64'(mon_e.instr[19:15]));
        chk($sformatf("rs2@%08h", mon_e.instr), 64'(rs2_64), 64'(mon_e.instr[24:20]));
        chk($sformatf("funct3@%08h", mon_e.instr), 64'(f3_64), 64'(mon_e.instr[14:12]));
        chk($sformatf("funct7@%08h", mon_e.instr), 64'(f7_64), 64'(mon_e.instr[31:25]));
        chk($sformatf("illegal64@%08h", mon_e.instr), 64'(il64), 64'(mon_e.ill64));
        chk($sformatf("illegal32@%08h", mon_e.instr), 64'(il32), 64'(mon_e.ill32));
        chk($sformatf("control64@%08h", mon_e.instr), 64'(c64), 64'(mon_e.c64));
        chk($sformatf("control32@%08h", mon_e.instr), 64'(c32), 64'(mon_e.c32));
        chk($sformatf("muldiv64@%08h", mon_e.instr), 64'(md64), 64'(mon_e.md));
        chk($sformatf("muldiv32@%08h", mon_e.instr), 64'(md32), 64'(mon_e.md));
        if (!mon_e.ill64) chk($sformatf("imm64@%08h", mon_e.instr), imm64, mon_e.imm);
        if (!mon_e.ill32) chk($sformatf("imm32@%08h", mon_e.instr), 64'(imm32), {32'h0, mon_e.imm[31:0]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input exp_t e);
    int t = 0;
    in_valid = 1'b1;  in_instruction = e.instr;  in_pc = e.pc;
    while (!r64 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!r64) begin
      chk("send_timeout_in_ready", 64'(r64), 64'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid64"}, 64'(v64), 64'd0);
    chk({tag, "_valid32"}, 64'(v32), 64'd0);
    chk({tag, "_in_ready64"}, 64'(r64), 64'd1);
    chk({tag, "_in_ready32"}, 64'(r32), 64'd1);
    chk({tag, "_pc64"}, pc64, TAG64);
    chk({tag, "_pc32"}, 64'(pc32), 64'(TAG32));
  endtask

  initial begin
    exp_t e;
    vec.push_back(mk(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, ctl(A_ADD,1,1,0,0,0,0), ctl(A_ADD,1,1,0,0,0,0), 0, 0, 0));
    vec.push_back(mk(32'h123452B7, 64'h0000_0000_1234_5000, ctl(A_ADD,1,1,0,0,0,0), ctl(A_ADD,1,1,0,0,0,0), 0, 0, 0));
    vec.push_back(mk(32'h800000B7, 64'hFFFF_FFFF_8000_0000, ctl(A_ADD,1,1,0,0,0,0), ctl(A_ADD,1,1,0,0,0,0), 0, 0, 0));
    vec.push_back(mk(32'h00000000, 64'h0, 10'h0, 10'h0, 1, 1, 0));
    vec.push_back(mk(32'h00003003, 64'h0, ctl(A_ADD,1,1,1,0,0,0), 10'h0, 0, 1, 0));
`ifdef RISCV_MEXT_EN
    vec.push_back(mk(32'h022081B3, 64'h0, ctl(A_ADD,1,0,0,0,0,0), ctl(A_ADD,1,0,0,0,0,0), 0, 0, 1));
`else
    vec.push_back(mk(32'h022081B3, 64'h0, 10'h0, 10'h0, 1, 1, 0));
`endif
    vec.push_back(mk(32'h402081B3, 64'h0, ctl(A_SUB,1,0,0,0,0,0), ctl(A_SUB,1,0,0,0,0,0), 0, 0, 0));
    vec.push_back(mk(32'hFE208EE3, 64'hFFFF_FFFF_FFFF_FFFC, ctl(A_SUB,0,0,0,0,1,0), ctl(A_SUB,0,0,0,0,1,0), 0, 0, 0));
    vec.push_back(mk(32'h0020A423, 64'h8, ctl(A_ADD,0,1,0,1,0,0), ctl(A_ADD,0,1,0,1,0,0), 0, 0, 0));
    vec.push_back(mk(32'h001000EF, 64'h800, ctl(A_ADD,1,1,0,0,0,1), ctl(A_ADD,1,1,0,0,0,1), 0, 0, 0));
    vec.push_back(mk(32'h000080E7, 64'h0, ctl(A_ADD,1,1,0,0,0,1), ctl(A_ADD,1,1,0,0,0,1), 0, 0, 0));
    vec.push_back(mk(32'h000090E7, 64'h0, 10'h0, 10'h0, 1, 1, 0));
    vec.push_back(mk(32'h4010D093, 64'h401, ctl(A_SRA,1,1,0,0,0,0), ctl(A_SRA,1,1,0,0,0,0), 0, 0, 0));
    vec.push_back(mk(32'h02009093, 64'h20, ctl(A_SLL,1,1,0,0,0,0), 10'h0, 0, 1, 0));
    vec.push_back(mk(32'h40009093, 64'h0, 10'h0, 10'h0, 1, 1, 0));
    vec.push_back(mk(32'h00001117, 64'h1000, ctl(A_ADD,1,1,0,0,0,0), ctl(A_ADD,1,1,0,0,0,0), 0, 0, 0));
    vec.push_back(mk(32'h0040A183, 64'h4, ctl(A_ADD,1,1,1,0,0,0), ctl(A_ADD,1,1,1,0,0,0), 0, 0, 0));
    vec.push_back(mk(32'h00000090, 64'h0, 10'h0, 10'h0, 1, 1, 0));
    for (int i = 0; i < vec.size(); i++) vec[i].pc = 64'h0000_0001_8000_0000 + 64'(i) * 64'd4;

    // reset values, before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk_idle("reset");
    chk("reset_imm64", imm64, 64'h0);
    chk("reset_control64", 64'(c64), 64'h0);
    chk("reset_rd64", 64'(rd64), 64'h0);
    chk("reset_illegal64", 64'(il64), 64'h0);
    chk("reset_muldiv64", 64'(md64), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // back-to-back stream at full throughput
    out_ready = 1'b1;
    foreach (vec[i]) send(vec[i]);
    drain();

    // backpressure: A, B fill the buffer, C waits
    out_ready = 1'b0;
    send(vec[0]);
    send(vec[1]);
    chk("full_in_ready64", 64'(r64), 64'd0);
    chk("full_in_ready32", 64'(r32), 64'd0);
    chk("stall_head_pc", pc64, vec[0].pc);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send(vec[6]);
    drain();

    // irregular out_ready pattern
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          @(posedge clk); #1;
          out_ready = (k % 3) != 0;
        end
        out_ready = 1'b1;
      end
      begin
        foreach (vec[i]) send(vec[i]);
      end
    join
    drain();

    // flush while FULL with a same-cycle offer
    out_ready = 1'b0;
    send(vec[0]);
    send(vec[1]);
    flush = 1'b1;  in_valid = 1'b1;  in_instruction = vec[7].instr;  in_pc = vec[7].pc;
    @(posedge clk); #1;
    flush = 1'b0;  in_valid = 1'b0;
    sb.delete();
    chk_idle("flush_full");

    // flush while EMPTY with an offer that would otherwise be accepted
    flush = 1'b1;  in_valid = 1'b1;  in_instruction = vec[8].instr;  in_pc = vec[8].pc;
    @(posedge clk); #1;
    flush = 1'b0;  in_valid = 1'b0;
    chk_idle("flush_empty");
    out_ready = 1'b1;
    send(vec[9]);
    drain();

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(vec[0]);
    send(vec[1]);
    #3 rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_control64", 64'(c64), 64'h0);
    chk("async_reset_rd64", 64'(rd64), 64'h0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    e = vec[2];
    send(e);
    drain();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
